varredura_matriz_leds: RTL and testbench



---
 rtl/pacote_batalha_naval.sv | 22 ++
 rtl/contador_modulo.sv | 36 +++
 rtl/varredura_matriz_leds.sv | 116 +++++++++++
 tb/tb_varredura_matriz_leds.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pacote_batalha_naval.sv
`default_nettype none
// ============================================================================
//  Module      : pacote_batalha_naval (package)
//  Description : Board dimensions and active-low idle patterns shared by the
//                attack manager and the LED matrix scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
package pacote_batalha_naval;

    localparam int N_COLUNAS = 5;
    localparam int N_LINHAS  = 7;

    localparam logic [N_COLUNAS-1:0] COLUNAS_OFF = '1;
    localparam logic [N_LINHAS-1:0]  LINHAS_OFF  = '1;

    // Active-low one-hot column select for a column index.
    function automatic logic [N_COLUNAS-1:0] seleciona_coluna(input logic [2:0] indice);
        return ~(N_COLUNAS'(1) << indice);
    endfunction

endpackage
`default_nettype wire

// File: rtl/contador_modulo.sv
`default_nettype none
// ============================================================================
//  Module      : contador_modulo
//  Description : Modulo-N up counter with synchronous clear and a gated
//                terminal-count output (fim is high only while counting).
//  Revision    : 1.0 - initial release
// ============================================================================
module contador_modulo #(
    parameter  int MODULO  = 2,
    localparam int LARGURA = (MODULO > 1) ? $clog2(MODULO) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               limpa,
    input  logic               habilita,
    output logic [LARGURA-1:0] valor,
    output logic               fim
);

    localparam logic [LARGURA-1:0] c_ULTIMO = LARGURA'(MODULO - 1);

    logic w_no_ultimo;

    assign w_no_ultimo = (valor == c_ULTIMO);
    assign fim         = habilita && w_no_ultimo;

    always_ff @(posedge clock) begin
        if (reset || limpa) begin
            valor <= '0;
        end else if (habilita) begin
            valor <= w_no_ultimo ? '0 : valor + LARGURA'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/varredura_matriz_leds.sv
`default_nettype none
// ============================================================================
//  Module      : varredura_matriz_leds
//  Description : Multiplexed 5x7 LED matrix scanner with per-slot blanking and
//                a blinking cursor overlay at the player's aim coordinate.
//  Revision    : 1.0 - initial release
// ============================================================================
module varredura_matriz_leds
    import pacote_batalha_naval::*;
#(
    parameter int DIV_COLUNA    = 50000,
    parameter int BLANK         = 8,
    parameter int QUADROS_PISCA = 25
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_LINHAS-1:0]  matriz0,
    input  logic [N_LINHAS-1:0]  matriz1,
    input  logic [N_LINHAS-1:0]  matriz2,
    input  logic [N_LINHAS-1:0]  matriz3,
    input  logic [N_LINHAS-1:0]  matriz4,
    input  logic [2:0]           coordColuna,
    input  logic [2:0]           coordLinha,
    output logic [N_COLUNAS-1:0] colunas,
    output logic [N_LINHAS-1:0]  linhas,
    output logic                 fim_quadro
);

    localparam int c_LARG_PRESC  = (DIV_COLUNA > 1) ? $clog2(DIV_COLUNA) : 1;
    localparam int c_LARG_COL    = $clog2(N_COLUNAS);
    localparam int c_LARG_QUADRO = (QUADROS_PISCA > 1) ? $clog2(QUADROS_PISCA) : 1;

    localparam logic [c_LARG_PRESC-1:0] c_BLANK = c_LARG_PRESC'(BLANK);

    logic                      w_limpa;
    logic [c_LARG_PRESC-1:0]   w_presc;
    logic                      w_fim_presc;
    logic [c_LARG_COL-1:0]     w_coluna;
    logic                      w_fim_quadro;
    logic [c_LARG_QUADRO-1:0]  w_unused_quadro;
    logic                      w_vira_fase;
    logic                      w_cursor_aqui;
    logic [N_LINHAS-1:0]       w_pixel;
    logic                      r_fase;

    // Counters hold the slot position about to be displayed; the output
    // registers load that position's pattern on the same edge they advance.
    assign w_limpa = ~enable;

    contador_modulo #(.MODULO(DIV_COLUNA)) u_prescaler (
        .clock    (clock),
        .reset    (reset),
        .limpa    (w_limpa),
        .habilita (enable),
        .valor    (w_presc),
        .fim      (w_fim_presc)
    );

    contador_modulo #(.MODULO(N_COLUNAS)) u_coluna (
        .clock    (clock),
        .reset    (reset),
        .limpa    (w_limpa),
        .habilita (w_fim_presc),
        .valor    (w_coluna),
        .fim      (w_fim_quadro)
    );

    contador_modulo #(.MODULO(QUADROS_PISCA)) u_quadros (
        .clock    (clock),
        .reset    (reset),
        .limpa    (w_limpa),
        .habilita (w_fim_quadro),
        .valor    (w_unused_quadro),
        .fim      (w_vira_fase)
    );

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            r_fase <= 1'b0;
        end else if (w_vira_fase) begin
            r_fase <= ~r_fase;
        end
    end

    assign w_cursor_aqui = (coordColuna == w_coluna) && (coordLinha < 3'(N_LINHAS));

    // Phase 0 inverts the cursor cell so both hit and unhit cells visibly flash.
    always_comb begin
        w_pixel = matriz0;
        case (w_coluna)
            3'd1:    w_pixel = matriz1;
            3'd2:    w_pixel = matriz2;
            3'd3:    w_pixel = matriz3;
            3'd4:    w_pixel = matriz4;
            default: w_pixel = matriz0;
        endcase
        if (w_cursor_aqui && !r_fase) begin
            w_pixel = w_pixel ^ (N_LINHAS'(1) << coordLinha);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            colunas    <= COLUNAS_OFF;
            linhas     <= LINHAS_OFF;
            fim_quadro <= 1'b0;
        end else begin
            colunas    <= seleciona_coluna(w_coluna);
            linhas     <= (w_presc < c_BLANK) ? LINHAS_OFF : ~w_pixel;
            fim_quadro <= w_fim_quadro;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_varredura_matriz_leds.sv
`default_nettype none
// ============================================================================
//  Module      : tb_varredura_matriz_leds
//  Description : Self-checking bench for the LED matrix scanner, compared
//                cycle by cycle against a position-count reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_varredura_matriz_leds;

    localparam int DIV = 4;
    localparam int BLK = 1;
    localparam int QP  = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [6:0] matriz0, matriz1, matriz2, matriz3, matriz4;
    logic [2:0] coordColuna, coordLinha;
    logic [4:0] colunas;
    logic [6:0] linhas;
    logic       fim_quadro;

    int n_verif  = 0;
    int n_falhas = 0;

    varredura_matriz_leds #(
        .DIV_COLUNA    (DIV),
        .BLANK         (BLK),
        .QUADROS_PISCA (QP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .matriz0     (matriz0),
        .matriz1     (matriz1),
        .matriz2     (matriz2),
        .matriz3     (matriz3),
        .matriz4     (matriz4),
        .coordColuna (coordColuna),
        .coordLinha  (coordLinha),
        .colunas     (colunas),
        .linhas      (linhas),
        .fim_quadro  (fim_quadro)
    );

    always #5 clock = ~clock;

    // Reference: n counts enabled cycles since restart; slot, column, frame
    // and blink phase follow from plain division of n.
    int         n;
    int         ref_p, ref_c, ref_fase;
    logic [6:0] ref_m [5];
    logic [6:0] ref_w;
    logic [4:0] esp_col;
    logic [6:0] esp_lin;
    logic       esp_fim;

    always @(posedge clock) begin
        if (reset || !enable) begin
            n       = 0;
            esp_col = 5'h1f;
            esp_lin = 7'h7f;
            esp_fim = 1'b0;
        end else begin
            ref_p    = n % DIV;
            ref_c    = (n / DIV) % 5;
            ref_fase = (n / (5 * DIV * QP)) % 2;
            ref_m    = '{matriz0, matriz1, matriz2, matriz3, matriz4};
            ref_w    = ref_m[ref_c];
            if (int'(coordColuna) == ref_c && coordLinha <= 3'd6 && ref_fase == 0)
                ref_w[coordLinha] = ~ref_w[coordLinha];
            esp_col        = 5'h1f;
            esp_col[ref_c] = 1'b0;
            esp_lin        = (ref_p < BLK) ? 7'h7f : ~ref_w;
            esp_fim        = (ref_c == 4 && ref_p == DIV - 1);
            n++;
        end
    end

    task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
        n_verif++;
        if (obtido !== esperado) begin
            n_falhas++;
            $display("FAIL %s @%0t: obtido %b esperado %b", tag, $time, obtido, esperado);
        end
    endtask

    task automatic ciclos(input int k);
        repeat (k) begin
            @(negedge clock);
            verifica("colunas", 32'(colunas), 32'(esp_col));
            verifica("linhas", 32'(linhas), 32'(esp_lin));
            verifica("fim_quadro", 32'(fim_quadro), 32'(esp_fim));
        end
    endtask

    task automatic reinicia();
        reset = 1'b1;
        ciclos(1);
        reset = 1'b0;
    endtask

    task automatic zera_matriz();
        matriz0 = '0; matriz1 = '0; matriz2 = '0; matriz3 = '0; matriz4 = '0;
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        coordColuna = 3'd7;
        coordLinha  = 3'd7;
        zera_matriz();

        // Reset then idle with enable low
        ciclos(3);
        reset = 1'b0;
        ciclos(40);

        // Plain scan, no cursor
        enable = 1'b1;
        ciclos(60);

        // Data and blanking
        matriz0 = 7'b1110001;
        matriz4 = 7'b1110000;
        ciclos(40);

        // Cursor blink on an empty cell, then on a hit cell
        reinicia();
        zera_matriz();
        coordColuna = 3'd2;
        coordLinha  = 3'd5;
        ciclos(160);
        matriz2 = 7'b0100000;
        ciclos(160);

        // Mid-scan reset (lands at column 3, p=2), then mid-scan enable drop
        reinicia();
        ciclos(14);
        reinicia();
        ciclos(25);
        enable = 1'b0;
        ciclos(1);
        enable = 1'b1;
        ciclos(25);

        // Live update in column 1's slot at p=1
        reinicia();
        zera_matriz();
        coordColuna = 3'd7;
        ciclos(6);
        matriz1 = 7'b0000001;
        ciclos(2);
        verifica("vivo_literal", 32'(linhas), 32'(7'b1111110));
        ciclos(1);

        // Randomized inputs, occasional reset and enable drops
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                matriz0 = 7'($urandom); matriz1 = 7'($urandom); matriz2 = 7'($urandom);
                matriz3 = 7'($urandom); matriz4 = 7'($urandom);
            end
            if ($urandom_range(0, 15) == 0) begin
                coordColuna = 3'($urandom_range(0, 7));
                coordLinha  = 3'($urandom_range(0, 7));
            end
            reset  = ($urandom_range(0, 99) == 0);
            enable = ($urandom_range(0, 59) != 0);
            ciclos(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_verif, n_falhas);
        $finish;
    end

endmodule
`default_nettype wire
